sdram_ref_ctrl: RTL



---
 rtl/sdram_pkg.sv | 21 ++
 rtl/sdram_ref_timer.sv | 48 ++++
 rtl/sdram_ref_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/sdram_pkg.sv
// Shared SDRAM command encodings ({cs_n,ras_n,cas_n,we_n}) and refresh FSM states.
// Used by the init, arbiter and refresh blocks.
package sdram_pkg;

   localparam logic [3:0] NOP          = 4'b0111;
   localparam logic [3:0] PRECHARGE    = 4'b0010;
   localparam logic [3:0] AUTO_REFRESH = 4'b0001;
   localparam logic [3:0] ACTIVE       = 4'b0011;
   localparam logic [3:0] READ         = 4'b0101;
   localparam logic [3:0] WRITE        = 4'b0100;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRE,
      ST_TRP,
      ST_AR,
      ST_TRFC,
      ST_END
   } ref_state_t;

endpackage

// File: rtl/sdram_ref_timer.sv
// Refresh interval tick generator and refresh debt tracker with sticky overflow.
module sdram_ref_timer #(
   parameter int REF_INTERVAL_CLK = 781,
   parameter int MAX_DEBT         = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       init_end,
   input  logic       ref_end,
   output logic [3:0] debt,
   output logic       overflow
);

   localparam int CNT_W = (REF_INTERVAL_CLK > 1) ? $clog2(REF_INTERVAL_CLK) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REF_INTERVAL_CLK - 1);
   localparam logic [3:0] DEBT_MAX = 4'(MAX_DEBT);

   logic [CNT_W-1:0] cnt;
   logic             tick;

   assign tick = init_end && (cnt == CNT_LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt      <= '0;
         debt     <= '0;
         overflow <= 1'b0;
      end else begin
         if (init_end)
            cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
         // A tick landing with ref_end cancels out; a tick at saturation only flags
         case ({tick, ref_end})
            2'b10: begin
               if (debt == DEBT_MAX)
                  overflow <= 1'b1;
               else
                  debt <= debt + 4'd1;
            end
            2'b01: begin
               if (debt != '0)
                  debt <= debt - 4'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/sdram_ref_ctrl.sv
// SDRAM auto-refresh controller: PRECHARGE-all then a burst of AUTO_REFRESH per grant.
// Optional SDRAM_REF_STAT_EN adds ref_stat_cnt, a wrapping count of completed sequences.
module sdram_ref_ctrl
   import sdram_pkg::*;
#(
   parameter int REF_INTERVAL_CLK = 781,
   parameter int TRP_CLK          = 2,
   parameter int TRFC_CLK         = 7,
   parameter int REF_BURST        = 2,
   parameter int MAX_DEBT         = 8,
   parameter int URGENT_LVL       = 6,
   parameter int BA_W             = 2,
   parameter int ADDR_W           = 13
) (
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   input  logic              init_end,
   input  logic              ref_en,
   output logic              ref_req,
   output logic              ref_urgent,
   output logic [3:0]        ref_cmd,
   output logic [BA_W-1:0]   ref_ba,
   output logic [ADDR_W-1:0] ref_addr,
   output logic              ref_end,
   output logic [3:0]        ref_debt,
   output logic              ref_overflow
`ifdef SDRAM_REF_STAT_EN
   ,output logic [15:0]      ref_stat_cnt
`endif
);

   localparam int WAIT_MAX = (TRP_CLK > TRFC_CLK) ? TRP_CLK : TRFC_CLK;
   localparam int WAIT_W   = $clog2(WAIT_MAX + 1);
   localparam logic [WAIT_W-1:0] TRP_LAST  = WAIT_W'(TRP_CLK - 1);
   localparam logic [WAIT_W-1:0] TRFC_LAST = WAIT_W'(TRFC_CLK - 1);
   localparam logic [2:0]        BURST     = 3'(REF_BURST);

   ref_state_t        state, state_nxt;
   logic [WAIT_W-1:0] wait_cnt, wait_nxt;
   logic [2:0]        ref_cnt, ref_cnt_nxt;
   logic [3:0]        cmd_nxt;

   sdram_ref_timer #(
      .REF_INTERVAL_CLK(REF_INTERVAL_CLK),
      .MAX_DEBT        (MAX_DEBT)
   ) u_timer (
      .clk     (sys_clk),
      .rst_n   (sys_rst_n),
      .init_end(init_end),
      .ref_end (ref_end),
      .debt    (ref_debt),
      .overflow(ref_overflow)
   );

   assign ref_ba     = '1;
   assign ref_addr   = '1;
   assign ref_end    = (state == ST_END);
   assign ref_req    = (ref_debt != '0) && (state == ST_IDLE);
   assign ref_urgent = (ref_debt >= 4'(URGENT_LVL));

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         state    <= ST_IDLE;
         wait_cnt <= '0;
         ref_cnt  <= '0;
         ref_cmd  <= NOP;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_nxt;
         ref_cnt  <= ref_cnt_nxt;
         ref_cmd  <= cmd_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      wait_nxt    = '0;
      ref_cnt_nxt = ref_cnt;
      cmd_nxt     = NOP;
      case (state)
         ST_IDLE: begin
            ref_cnt_nxt = '0;
            if (ref_en && init_end && (ref_debt != '0))
               state_nxt = ST_PRE;
         end
         ST_PRE: begin
            cmd_nxt   = PRECHARGE;
            state_nxt = ST_TRP;
         end
         ST_TRP: begin
            if (wait_cnt == TRP_LAST)
               state_nxt = ST_AR;
            else
               wait_nxt = wait_cnt + 1'b1;
         end
         ST_AR: begin
            cmd_nxt     = AUTO_REFRESH;
            ref_cnt_nxt = ref_cnt + 3'd1;
            state_nxt   = ST_TRFC;
         end
         ST_TRFC: begin
            if (wait_cnt == TRFC_LAST)
               state_nxt = (ref_cnt == BURST) ? ST_END : ST_AR;
            else
               wait_nxt = wait_cnt + 1'b1;
         end
         ST_END:  state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

`ifdef SDRAM_REF_STAT_EN
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n)
         ref_stat_cnt <= '0;
      else if (state == ST_END)
         ref_stat_cnt <= ref_stat_cnt + 16'd1;
   end
`endif

endmodule
